// File: rtl/actel_cfg_pkg.sv
// Shared constants, state encoding and helpers for the S1 configuration loader.
package actel_cfg_pkg;

  localparam int CELL_BITS = 7;

  // Bit offsets of each static pin inside a 7-bit cell slice
  localparam int D00_OFS = 6;
  localparam int D01_OFS = 5;
  localparam int D10_OFS = 4;
  localparam int D11_OFS = 3;
  localparam int A1_OFS  = 2;
  localparam int B1_OFS  = 1;
  localparam int A0_OFS  = 0;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SHIFT     = 3'd1,
    PARITY    = 3'd2,
    CHECK_OK  = 3'd3,
    CHECK_BAD = 3'd4,
    DONE      = 3'd5,
    ERROR     = 3'd6
  } cfg_state_e;

  function automatic logic state_accepts_bits(cfg_state_e s);
    return (s == SHIFT) || (s == PARITY);
  endfunction

endpackage

// File: rtl/actel_cfg_shift_reg.sv
// Shadow shift register with running XOR parity; clear has priority over shift.
module actel_cfg_shift_reg
  import actel_cfg_pkg::*;
#(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] data,
  output logic             parity
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             parity_q, parity_d;

  always_comb begin
    data_d   = data_q;
    parity_d = parity_q;
    if (clear) begin
      data_d   = '0;
      parity_d = 1'b0;
    end else if (shift_en) begin
      data_d   = {data_q[WIDTH-2:0], bit_in};
      parity_d = parity_q ^ bit_in;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      data_q   <= '0;
      parity_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      parity_q <= parity_d;
    end
  end

  assign data   = data_q;
  assign parity = parity_q;

endmodule

// File: rtl/actel_s1_cfg_loader.sv
// Serial configuration loader for a column of S1 cells: shifts a bitstream into a
// shadow register, checks an even-parity trailer and only then commits cell_cfg.
module actel_s1_cfg_loader
  import actel_cfg_pkg::*;
#(
  parameter int NUM_CELLS = 4
) (
  input  logic                            clk,
  input  logic                            clr,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            cfg_valid,
  input  logic                            cfg_bit,
  output logic                            cfg_ready,
  output logic [NUM_CELLS*CELL_BITS-1:0]  cell_cfg,
  output logic                            busy,
  output logic                            loaded,
  output logic                            err,
  output logic                            done
);

  localparam int TOTAL_BITS = NUM_CELLS * CELL_BITS;
  localparam int CNT_W      = $clog2(TOTAL_BITS + 1);

  cfg_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0] cell_cfg_q, cell_cfg_d;
  logic                  busy_q, busy_d;
  logic                  loaded_q, loaded_d;
  logic                  err_q, err_d;
  logic                  done_q, done_d;

  logic                  sr_clear, sr_shift;
  logic [TOTAL_BITS-1:0] shadow;
  logic                  par_acc;
  logic                  xfer;

  // busy_q doubles as cfg_ready: both are high exactly in SHIFT and PARITY
  assign xfer = cfg_valid & busy_q;

  actel_cfg_shift_reg #(.WIDTH(TOTAL_BITS)) u_shift (
    .clk      (clk),
    .clr      (clr),
    .clear    (sr_clear),
    .shift_en (sr_shift),
    .bit_in   (cfg_bit),
    .data     (shadow),
    .parity   (par_acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cell_cfg_d = cell_cfg_q;
    loaded_d   = loaded_q;
    err_d      = err_q;
    done_d     = 1'b0;
    sr_clear   = 1'b0;
    sr_shift   = 1'b0;

    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          sr_clear = 1'b1;
          loaded_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_d  = IDLE;
          loaded_d = 1'b0;
          err_d    = 1'b0;
        end else if (xfer) begin
          sr_shift = 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(TOTAL_BITS - 1)) state_d = PARITY;
        end
      end
      PARITY: begin
        if (abort) begin
          state_d  = IDLE;
          loaded_d = 1'b0;
          err_d    = 1'b0;
        end else if (xfer) begin
          state_d = (par_acc ^ cfg_bit) ? CHECK_BAD : CHECK_OK;
        end
      end
      CHECK_OK: begin
        cell_cfg_d = shadow;
        loaded_d   = 1'b1;
        done_d     = 1'b1;
        state_d    = DONE;
      end
      CHECK_BAD: begin
        err_d   = 1'b1;
        done_d  = 1'b1;
        state_d = ERROR;
      end
      default: state_d = IDLE;
    endcase

    busy_d = state_accepts_bits(state_d);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cell_cfg_q <= '0;
      busy_q     <= 1'b0;
      loaded_q   <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cell_cfg_q <= cell_cfg_d;
      busy_q     <= busy_d;
      loaded_q   <= loaded_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end

  assign cfg_ready = busy_q;
  assign busy      = busy_q;
  assign cell_cfg  = cell_cfg_q;
  assign loaded    = loaded_q;
  assign err       = err_q;
  assign done      = done_q;

endmodule
